// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO-side FSM encodings, default sizes and clog2 helper
package fifo_pkg;

   // Default geometry of one FIFO entry and of the read-side packer
   localparam int defaultDataWidth = 8;
   localparam int defaultPackRatio = 4;

   // Read-packer FSM; FLUSH_WAIT is only reachable when FIFO_PACKER_FLUSH_EN is defined
   typedef enum logic [1:0] {
      FILL       = 2'd0,
      FULL_WAIT  = 2'd1,
      FLUSH_WAIT = 2'd2
   } packState_t;

   // Ceiling log2 for sizing pointers and counters at elaboration time
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/pack_lane_reg.sv
// rtl/pack_lane_reg.sv - lane accumulator with indexed write and whole-word clear
module pack_lane_reg
   import fifo_pkg::*;
#(
   parameter int dataWidth  = defaultDataWidth,
   parameter int packRatio  = defaultPackRatio,
   parameter int indexWidth = clog2(packRatio)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clear,
   input  logic                          writeEnable,
   input  logic [indexWidth-1:0]         writeIndex,
   input  logic [dataWidth-1:0]          writeData,
   output logic [dataWidth*packRatio-1:0] lanes
);

   // Clearing on emission keeps unused lanes of a flushed partial word at zero
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         lanes <= '0;
      end else if (writeEnable) begin
         lanes[writeIndex*dataWidth +: dataWidth] <= writeData;
      end
   end

endmodule

// File: rtl/fifo_read_packer.sv
// rtl/fifo_read_packer.sv - packs narrow FIFO entries into wide words; FIFO_PACKER_FLUSH_EN enables partial-word flush
module fifo_read_packer
   import fifo_pkg::*;
#(
   parameter int dataWidth  = defaultDataWidth,
   parameter int packRatio  = defaultPackRatio,
   parameter int countWidth = clog2(packRatio) + 1
) (
   input  logic                           clkIn,
   input  logic                           rstIn,
   input  logic [dataWidth-1:0]           fifoDataIn,
   input  logic                           fifoEmptyIn,
   output logic                           fifoReadEnableOut,
   input  logic                           flushIn,
   output logic [dataWidth*packRatio-1:0] packDataOut,
   output logic [packRatio-1:0]           packMaskOut,
   output logic                           packValidOut,
   input  logic                           packReadyIn
);

   localparam int indexWidth = clog2(packRatio);
   localparam int wordWidth  = dataWidth * packRatio;
   localparam logic [countWidth-1:0] lastLane  = countWidth'(packRatio - 1);
   localparam logic [countWidth-1:0] fullCount = countWidth'(packRatio);
   localparam logic [countWidth:0]   ratioWide = (countWidth + 1)'(packRatio);

   packState_t                state;
   packState_t                stateNext;
   logic [countWidth-1:0]     laneCount;
   logic [countWidth-1:0]     laneCountNext;
   logic                      pendingRead;
   logic [countWidth:0]       inFlight;
   logic                      outFree;
   logic                      lastCapture;
   logic                      validNext;
   logic [wordWidth-1:0]      dataNext;
   logic                      laneWrite;
   logic                      laneClear;
   logic [wordWidth-1:0]      lanes;

`ifdef FIFO_PACKER_FLUSH_EN
   logic [packRatio-1:0]      maskNext;
   logic [packRatio-1:0]      flushMask;
`else
   logic                      unusedFlush;
   assign unusedFlush = flushIn;
`endif

   // Captured lanes plus the entry still on its way; one bit wider so it never wraps
   assign inFlight = {1'b0, laneCount} + {{countWidth{1'b0}}, pendingRead};

   // Output register can take a new word if empty or being drained this cycle
   assign outFree = !packValidOut || packReadyIn;

   // The entry landing this cycle completes the word
   assign lastCapture = pendingRead && (laneCount == lastLane);

   // Reads only in FILL and only while the word has room for one more entry
   assign fifoReadEnableOut = (state == FILL) && !fifoEmptyIn && (inFlight < ratioWide) && !rstIn;

   pack_lane_reg #(
      .dataWidth  (dataWidth),
      .packRatio  (packRatio),
      .indexWidth (indexWidth)
   ) laneReg (
      .clk         (clkIn),
      .rst         (rstIn),
      .clear       (laneClear),
      .writeEnable (laneWrite),
      .writeIndex  (laneCount[indexWidth-1:0]),
      .writeData   (fifoDataIn),
      .lanes       (lanes)
   );

`ifdef FIFO_PACKER_FLUSH_EN
   // A flushed word is valid only in the lanes already captured
   always_comb begin
      flushMask = '0;
      for (int i = 0; i < packRatio; i++) begin
         flushMask[i] = (countWidth'(i) < laneCount);
      end
   end
`endif

   // Next-state, lane bookkeeping and output-register loads
   always_comb begin
      stateNext     = state;
      laneCountNext = laneCount;
      validNext     = packValidOut && !packReadyIn;
      dataNext      = packDataOut;
      laneWrite     = 1'b0;
      laneClear     = 1'b0;
`ifdef FIFO_PACKER_FLUSH_EN
      maskNext      = packMaskOut;
`endif
      case (state)
         FILL: begin
            if (pendingRead) begin
               if (lastCapture) begin
                  if (outFree) begin
                     // Final entry bypasses the accumulator straight into the output
                     dataNext      = {fifoDataIn, lanes[wordWidth-dataWidth-1:0]};
                     validNext     = 1'b1;
                     laneCountNext = '0;
                     laneClear     = 1'b1;
`ifdef FIFO_PACKER_FLUSH_EN
                     maskNext      = '1;
`endif
                  end else begin
                     laneWrite     = 1'b1;
                     laneCountNext = fullCount;
                     stateNext     = FULL_WAIT;
                  end
               end else begin
                  laneWrite     = 1'b1;
                  laneCountNext = laneCount + countWidth'(1);
               end
            end
`ifdef FIFO_PACKER_FLUSH_EN
            // A word completing this cycle already satisfies the flush
            if (flushIn && (inFlight != '0) && !lastCapture) begin
               stateNext = FLUSH_WAIT;
            end
`endif
         end
         FULL_WAIT: begin
            if (outFree) begin
               dataNext      = lanes;
               validNext     = 1'b1;
               laneCountNext = '0;
               laneClear     = 1'b1;
               stateNext     = FILL;
`ifdef FIFO_PACKER_FLUSH_EN
               maskNext      = '1;
`endif
            end
         end
`ifdef FIFO_PACKER_FLUSH_EN
         FLUSH_WAIT: begin
            // Land the in-flight entry first so it is part of the flushed word
            if (pendingRead) begin
               laneWrite     = 1'b1;
               laneCountNext = laneCount + countWidth'(1);
            end else if (outFree) begin
               dataNext      = lanes;
               maskNext      = flushMask;
               validNext     = 1'b1;
               laneCountNext = '0;
               laneClear     = 1'b1;
               stateNext     = FILL;
            end
         end
`endif
         default: begin
            stateNext = FILL;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clkIn) begin
      if (rstIn) begin
         state <= FILL;
      end else begin
         state <= stateNext;
      end
   end

   // Lane counter, in-flight read flag and output register; reset drops any partial word
   always_ff @(posedge clkIn) begin
      if (rstIn) begin
         laneCount    <= '0;
         pendingRead  <= 1'b0;
         packValidOut <= 1'b0;
         packDataOut  <= '0;
      end else begin
         laneCount    <= laneCountNext;
         pendingRead  <= fifoReadEnableOut;
         packValidOut <= validNext;
         packDataOut  <= dataNext;
      end
   end

`ifdef FIFO_PACKER_FLUSH_EN
   // Per-lane valid mask travels with the output word
   always_ff @(posedge clkIn) begin
      if (rstIn) begin
         packMaskOut <= '0;
      end else begin
         packMaskOut <= maskNext;
      end
   end
`else
   assign packMaskOut = '1;
`endif

endmodule

// File: tb/tb_fifo_read_packer.sv
// tb/tb_fifo_read_packer.sv - scoreboard bench for fifo_read_packer with a behavioural FIFO read port
module tb_fifo_read_packer;
   import fifo_pkg::*;

   localparam int dataWidth = 8;
   localparam int packRatio = 4;
   localparam int wordWidth = dataWidth * packRatio;

   typedef struct {
      logic [wordWidth-1:0] data;
      logic [packRatio-1:0] mask;
   } word_t;

   logic                 clkIn = 1'b0;
   logic                 rstIn;
   logic [dataWidth-1:0] fifoDataIn = '0;
   logic                 fifoEmptyIn;
   logic                 fifoReadEnableOut;
   logic                 flushIn;
   logic [wordWidth-1:0] packDataOut;
   logic [packRatio-1:0] packMaskOut;
   logic                 packValidOut;
   logic                 packReadyIn;

   int checks = 0;
   int failures = 0;

   // FIFO model: the initial block owns the write pointer, the clocked block the read side
   logic [dataWidth-1:0] fifoMem [0:255];
   int                   wrPtr = 0;
   int                   rdPtr = 0;
   int                   readCount = 0;
   logic                 badRead = 1'b0;

   // Output log and stall-stability monitor
   logic [wordWidth-1:0] gotData [0:63];
   logic [packRatio-1:0] gotMask [0:63];
   int                   gotCount = 0;
   logic                 stableBad = 1'b0;
   logic                 stallPrev = 1'b0;
   logic [wordWidth-1:0] prevData = '0;
   logic [packRatio-1:0] prevMask = '0;

   // Scoreboard model
   word_t                expQ [$];
   logic [wordWidth-1:0] modelLanes = '0;
   int                   modelCount = 0;
   int                   rdIdx = 0;
   logic                 toggleReady = 1'b0;

`ifdef FIFO_PACKER_FLUSH_EN
   localparam logic [packRatio-1:0] resetMask = '0;
`else
   localparam logic [packRatio-1:0] resetMask = '1;
`endif

   assign fifoEmptyIn = (rdPtr == wrPtr);

   always #5 clkIn = ~clkIn;

   fifo_read_packer dut (
      .clkIn             (clkIn),
      .rstIn             (rstIn),
      .fifoDataIn        (fifoDataIn),
      .fifoEmptyIn       (fifoEmptyIn),
      .fifoReadEnableOut (fifoReadEnableOut),
      .flushIn           (flushIn),
      .packDataOut       (packDataOut),
      .packMaskOut       (packMaskOut),
      .packValidOut      (packValidOut),
      .packReadyIn       (packReadyIn)
   );

   // FIFO read port: data appears the cycle after a read; reset empties the FIFO
   always @(posedge clkIn) begin
      if (rstIn) begin
         rdPtr <= wrPtr;
      end else if (fifoReadEnableOut) begin
         readCount <= readCount + 1;
         if (rdPtr == wrPtr) begin
            badRead <= 1'b1;
         end else begin
            fifoDataIn <= fifoMem[rdPtr];
            rdPtr      <= rdPtr + 1;
         end
      end
   end

   // Log accepted words and flag any change of data/mask while stalled
   always @(posedge clkIn) begin
      if (stallPrev && !rstIn && (packDataOut !== prevData || packMaskOut !== prevMask)) begin
         stableBad <= 1'b1;
      end
      stallPrev <= packValidOut && !packReadyIn && !rstIn;
      prevData  <= packDataOut;
      prevMask  <= packMaskOut;
      if (packValidOut && packReadyIn && !rstIn && gotCount < 64) begin
         gotData[gotCount] <= packDataOut;
         gotMask[gotCount] <= packMaskOut;
         gotCount          <= gotCount + 1;
      end
   end

   task automatic tick();
      @(posedge clkIn);
      #1;
      if (toggleReady) packReadyIn = ~packReadyIn;
   endtask

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic pushFifo(input logic [dataWidth-1:0] value);
      fifoMem[wrPtr] = value;
      wrPtr++;
   endtask

   task automatic pushEntry(input logic [dataWidth-1:0] value);
      word_t w;
      pushFifo(value);
      modelLanes[modelCount*dataWidth +: dataWidth] = value;
      modelCount++;
      if (modelCount == packRatio) begin
         w.data = modelLanes;
         w.mask = '1;
         expQ.push_back(w);
         modelLanes = '0;
         modelCount = 0;
      end
   endtask

   task automatic expectFlush();
      word_t w;
      w.data = modelLanes;
      w.mask = packRatio'((1 << modelCount) - 1);
      expQ.push_back(w);
      modelLanes = '0;
      modelCount = 0;
   endtask

   task automatic drain(input string tag, input int budget);
      word_t w;
      int    k;
      while (expQ.size() > 0) begin
         w = expQ.pop_front();
         k = 0;
         while (gotCount <= rdIdx && k < budget) begin
            tick();
            k++;
         end
         if (gotCount <= rdIdx) begin
            check({tag, " timeout"}, 32'(gotCount), 32'(rdIdx + 1));
            expQ.delete();
         end else begin
            check({tag, " data"}, gotData[rdIdx], w.data);
            check({tag, " mask"}, 32'(gotMask[rdIdx]), 32'(w.mask));
            rdIdx++;
         end
      end
   endtask

   initial begin
      int readStart;
      int validAt;
      int readsBefore;
      int sawRead;
      int sawValid;

      rstIn       = 1'b1;
      flushIn     = 1'b0;
      packReadyIn = 1'b1;
      tick();
      tick();
      check("reset valid", 32'(packValidOut), 32'd0);
      check("reset data", packDataOut, 32'd0);
      check("reset mask", 32'(packMaskOut), 32'(resetMask));
      check("reset rden", 32'(fifoReadEnableOut), 32'd0);
      rstIn = 1'b0;

      // Empty FIFO: nothing read, nothing emitted
      sawRead  = 0;
      sawValid = 0;
      for (int i = 0; i < 20; i++) begin
         if (fifoReadEnableOut) sawRead++;
         if (packValidOut) sawValid++;
         tick();
      end
      check("empty rden", 32'(sawRead), 32'd0);
      check("empty valid", 32'(sawValid), 32'd0);

      // Streaming with ready high, plus first-word latency
      for (int i = 0; i < 8; i++) pushEntry(8'(i));
      #1;
      readStart = -1;
      validAt   = -1;
      for (int k = 0; k < 16; k++) begin
         if (fifoReadEnableOut && readStart < 0) readStart = k;
         if (packValidOut && validAt < 0) validAt = k;
         tick();
      end
      check("latency", 32'(validAt - readStart), 32'(packRatio + 1));
      drain("stream", 40);

      // Backpressure: 8 pops then hold in FULL_WAIT
      packReadyIn = 1'b0;
      readsBefore = readCount;
      for (int i = 0; i < 8; i++) pushEntry(8'(8'h40 + i));
      for (int i = 0; i < 30; i++) tick();
      check("bp reads", 32'(readCount - readsBefore), 32'd8);
      check("bp rden", 32'(fifoReadEnableOut), 32'd0);
      check("bp valid", 32'(packValidOut), 32'd1);
      check("bp held data", packDataOut, expQ[0].data);
      check("bp state", 32'(dut.state), 32'(FULL_WAIT));
      check("bp stable", 32'(stableBad), 32'd0);
      packReadyIn = 1'b1;
      drain("bp release", 20);

      // Mid-word reset: captured lanes and FIFO contents are discarded
      pushEntry(8'h55);
      pushEntry(8'h66);
      for (int i = 0; i < 5; i++) tick();
      pushFifo(8'h77);
      rstIn = 1'b1;
      #1;
      check("midreset rden", 32'(fifoReadEnableOut), 32'd0);
      tick();
      check("midreset valid", 32'(packValidOut), 32'd0);
      check("midreset data", packDataOut, 32'd0);
      check("midreset mask", 32'(packMaskOut), 32'(resetMask));
      check("midreset lanes", 32'(dut.laneCount), 32'd0);
      rstIn      = 1'b0;
      modelLanes = '0;
      modelCount = 0;
      for (int i = 0; i < 4; i++) pushEntry(8'(8'h21 + i));
      drain("post reset", 40);

      // Ready toggling every cycle over four words
      toggleReady = 1'b1;
      for (int i = 0; i < 16; i++) pushEntry(8'(8'h80 + i * 3));
      drain("toggle", 60);
      toggleReady = 1'b0;
      packReadyIn = 1'b1;
      check("toggle stable", 32'(stableBad), 32'd0);

`ifdef FIFO_PACKER_FLUSH_EN
      // Partial-word flush then a normal full word
      pushEntry(8'hAA);
      pushEntry(8'hBB);
      for (int i = 0; i < 5; i++) tick();
      flushIn = 1'b1;
      tick();
      flushIn = 1'b0;
      expectFlush();
      drain("flush", 20);
      for (int i = 0; i < 4; i++) pushEntry(8'(8'h11 + i));
      drain("after flush", 40);
`endif

      for (int i = 0; i < 10; i++) tick();
      check("word count", 32'(gotCount), 32'(rdIdx));
      check("read when empty", 32'(badRead), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
